// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the display driver encoder and the capture/decode path.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Cathode bit positions (segment lines are active-low on the pins).
  localparam int CATH_A  = 7;
  localparam int CATH_B  = 6;
  localparam int CATH_C  = 5;
  localparam int CATH_D  = 4;
  localparam int CATH_E  = 3;
  localparam int CATH_F  = 2;
  localparam int CATH_G  = 1;
  localparam int CATH_DP = 0;

  // Active-low a..g patterns, a in the MSB, as seen on cathode[7:1].
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  // One decoded digit: {code, err, dp}.
  typedef struct packed {
    logic [3:0] code;
    logic       err;
    logic       dp;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{code: CODE_BLANK, err: 1'b0, dp: 1'b0};

  typedef enum logic {HUNT, COLLECT} frame_state_t;

  // Anode mapping: digit i is driven by anode bit i, active-high.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic anode_onehot(input logic [3:0] a);
    return (a != 4'h0) && ((a & (a - 4'd1)) == 4'h0);
  endfunction

  // Only meaningful for a one-hot anode value.
  function automatic logic [1:0] anode_index(input logic [3:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Decodes an active-low cathode pattern back to a BCD/blank/error code plus decimal point.
// Latency: purely combinational.
// Backpressure: none.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [7:0] cathode,
  output digit_t     digit
);

  // Pattern lookup; anything not in the table is reported as an error code
  always_comb begin
    digit.code = CODE_ERR;
    digit.err  = 1'b1;
    digit.dp   = ~cathode[CATH_DP];
    case (cathode[CATH_A:CATH_G])
      SEG_0:     begin digit.code = 4'd0;       digit.err = 1'b0; end
      SEG_1:     begin digit.code = 4'd1;       digit.err = 1'b0; end
      SEG_2:     begin digit.code = 4'd2;       digit.err = 1'b0; end
      SEG_3:     begin digit.code = 4'd3;       digit.err = 1'b0; end
      SEG_4:     begin digit.code = 4'd4;       digit.err = 1'b0; end
      SEG_5:     begin digit.code = 4'd5;       digit.err = 1'b0; end
      SEG_6:     begin digit.code = 4'd6;       digit.err = 1'b0; end
      SEG_7:     begin digit.code = 4'd7;       digit.err = 1'b0; end
      SEG_8:     begin digit.code = 4'd8;       digit.err = 1'b0; end
      SEG_9:     begin digit.code = 4'd9;       digit.err = 1'b0; end
      SEG_BLANK: begin digit.code = CODE_BLANK; digit.err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures stable digit phases from the multiplexed display bus and assembles 4-digit frames.
// Latency: capture STABLE_CYCLES-1 edges after a phase is first sampled; frame outputs one edge later.
// Backpressure: none; the bus is sampled every cycle and results are one-cycle pulses.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode,
  input  logic [7:0]  cathode,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        seq_err
);

  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  logic [3:0]   s_anode;
  logic [7:0]   s_cathode;
  logic [7:0]   count;
  logic         cap_vld;
  logic         same;
  logic         cap_onehot;
  logic [1:0]   cap_idx;
  digit_t       cur_digit;
  digit_t       shadow [3];

  frame_state_t state, state_nxt;
  logic [1:0]   exp, exp_nxt;
  logic         store, commit, seq_nxt;

  assign same = (anode == s_anode) && (cathode == s_cathode);

  // Input stage and saturating stability counter; cap_vld marks the edge the count reached STABLE_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_anode   <= 4'h0;
      s_cathode <= 8'hFF;
      count     <= 8'd0;
      cap_vld   <= 1'b0;
    end else begin
      s_anode   <= anode;
      s_cathode <= cathode;
      cap_vld   <= 1'b0;
      if (anode == 4'h0) begin
        count <= 8'd0;
      end else if (!same) begin
        count <= 8'd1;
      end else if (count != STABLE_MAX) begin
        count   <= count + 8'd1;
        cap_vld <= (count == STABLE_LAST);
      end
    end
  end

  // While cap_vld is high the input registers still hold the captured phase
  assign cap_onehot = anode_onehot(s_anode);
  assign cap_idx    = anode_index(s_anode);

  seg_pattern_decode u_decode (
    .cathode (s_cathode),
    .digit   (cur_digit)
  );

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      exp   <= 2'd0;
    end else begin
      state <= state_nxt;
      exp   <= exp_nxt;
    end
  end

  // Frame sequencing: hunt for digit 0, then collect 1..3 in order, discarding on any disorder
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp;
    store     = 1'b0;
    commit    = 1'b0;
    seq_nxt   = 1'b0;
    if (cap_vld) begin
      if (!cap_onehot) begin
        if (state == COLLECT) begin
          seq_nxt   = 1'b1;
          state_nxt = HUNT;
          exp_nxt   = 2'd0;
        end
      end else begin
        case (state)
          HUNT: begin
            if (cap_idx == 2'd0) begin
              store     = 1'b1;
              exp_nxt   = 2'd1;
              state_nxt = COLLECT;
            end
          end
          COLLECT: begin
            if (cap_idx == exp) begin
              store = 1'b1;
              if (exp == 2'd3) begin
                commit    = 1'b1;
                state_nxt = HUNT;
                exp_nxt   = 2'd0;
              end else begin
                exp_nxt = exp + 2'd1;
              end
            end else begin
              seq_nxt = 1'b1;
              if (cap_idx == 2'd0) begin
                store   = 1'b1;
                exp_nxt = 2'd1;
              end else begin
                state_nxt = HUNT;
                exp_nxt   = 2'd0;
              end
            end
          end
          default: begin
            state_nxt = HUNT;
            exp_nxt   = 2'd0;
          end
        endcase
      end
    end
  end

  // Shadow holds digits 0..2 of the frame in progress; digit 3 commits straight from the decoder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) shadow[i] <= DIGIT_BLANK;
      digits      <= 16'hFFFF;
      dp          <= 4'h0;
      digit_err   <= 4'h0;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      frame_valid <= commit;
      seq_err     <= seq_nxt;
      for (int i = 0; i < 3; i++) begin
        if (store && (cap_idx == 2'(i))) shadow[i] <= cur_digit;
      end
      if (commit) begin
        for (int i = 0; i < 3; i++) begin
          digits[4*i +: 4] <= shadow[i].code;
          dp[i]            <= shadow[i].dp;
          digit_err[i]     <= shadow[i].err;
        end
        digits[15:12] <= cur_digit.code;
        dp[3]         <= cur_digit.dp;
        digit_err[3]  <= cur_digit.err;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scenarios then random phases vs a run-length/frame model.
// Latency: model predicts captures STABLE_CYCLES-1 edges after a phase starts, outputs one edge later.
// Backpressure: none.
module tb_seg_scan_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  anode = 4'h0;
  logic [7:0]  cathode = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        seq_err;

  always #5 clk = ~clk;

  seg_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .anode       (anode),
    .cathode     (cathode),
    .digits      (digits),
    .dp          (dp),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .seq_err     (seq_err)
  );

  int checks = 0;
  int failures = 0;
  int fv_seen = 0;
  int se_seen = 0;

  // Segment table for digits 0..9, active-low, a..g.
  logic [6:0] tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  typedef struct packed {
    logic [3:0] c;
    logic       e;
    logic       d;
  } md_t;

  // Reference model state
  logic [11:0] m_prev;
  int          m_run;
  logic        m_pend;
  logic [11:0] m_pv;
  md_t         part[$];
  logic [15:0] e_dig;
  logic [3:0]  e_dp, e_err;
  logic        e_fv, e_se;

  function automatic md_t mdec(input logic [7:0] c);
    md_t r;
    r.d = ~c[0];
    r.c = 4'hE;
    r.e = 1'b1;
    if (c[7:1] == 7'h7F) begin
      r.c = 4'hF;
      r.e = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (c[7:1] == tab[i]) begin
        r.c = 4'(i);
        r.e = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg(input int d);
    return {tab[d], 1'b1};
  endfunction

  task automatic m_reset();
    m_prev = {4'h0, 8'hFF};
    m_run  = 0;
    m_pend = 1'b0;
    m_pv   = 12'h0;
    part.delete();
    e_dig = 16'hFFFF;
    e_dp  = 4'h0;
    e_err = 4'h0;
    e_fv  = 1'b0;
    e_se  = 1'b0;
  endtask

  // Apply one captured phase to the frame builder (empty queue == hunting for digit 0)
  task automatic m_event(input logic [11:0] v);
    logic [3:0] a;
    int idx;
    md_t d;
    a = v[11:8];
    if ($countones(a) != 1) begin
      if (part.size() > 0) begin
        e_se = 1'b1;
        part.delete();
      end
    end else begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (a[i]) idx = i;
      d = mdec(v[7:0]);
      if (part.size() == 0) begin
        if (idx == 0) part.push_back(d);
      end else if (idx == part.size()) begin
        part.push_back(d);
        if (part.size() == 4) begin
          for (int i = 0; i < 4; i++) begin
            e_dig[4*i +: 4] = part[i].c;
            e_err[i]        = part[i].e;
            e_dp[i]         = part[i].d;
          end
          e_fv = 1'b1;
          part.delete();
        end
      end else begin
        e_se = 1'b1;
        part.delete();
        if (idx == 0) part.push_back(d);
      end
    end
  endtask

  // One clock edge of the model: previous capture takes effect, then run-length bookkeeping
  task automatic m_edge(input logic [11:0] v);
    e_fv = 1'b0;
    e_se = 1'b0;
    if (m_pend) begin
      m_pend = 1'b0;
      m_event(m_pv);
    end
    if (v == m_prev) m_run++;
    else m_run = 1;
    m_prev = v;
    if (v[11:8] != 4'h0 && m_run == S) begin
      m_pend = 1'b1;
      m_pv   = v;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] a, input logic [7:0] c);
    anode   = a;
    cathode = c;
    @(posedge clk);
    m_edge({a, c});
    #1;
    chk("digits", digits, e_dig);
    chk("dp", {12'h0, dp}, {12'h0, e_dp});
    chk("digit_err", {12'h0, digit_err}, {12'h0, e_err});
    chk("frame_valid", {15'h0, frame_valid}, {15'h0, e_fv});
    chk("seq_err", {15'h0, seq_err}, {15'h0, e_se});
    if (frame_valid === 1'b1) fv_seen++;
    if (seq_err === 1'b1) se_seen++;
  endtask

  task automatic phase(input logic [3:0] a, input logic [7:0] c, input int n);
    for (int k = 0; k < n; k++) cyc(a, c);
  endtask

  task automatic scan4(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                       input logic [7:0] c3, input int n);
    phase(4'b0001, c0, n);
    phase(4'b0010, c1, n);
    phase(4'b0100, c2, n);
    phase(4'b1000, c3, n);
    phase(4'b0000, 8'hFF, 3);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits"}, digits, 16'hFFFF);
    chk({tag, "_dp"}, {12'h0, dp}, 16'h0);
    chk({tag, "_err"}, {12'h0, digit_err}, 16'h0);
    chk({tag, "_fv"}, {15'h0, frame_valid}, 16'h0);
    chk({tag, "_se"}, {15'h0, seq_err}, 16'h0);
  endtask

  int f0, s0;
  int ridx;
  logic [3:0] ra;
  logic [7:0] rc;
  int r, sel;

  initial begin
    m_reset();
    #1 rst_n = 1'b0;
    #11;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean scan 1,2,3,4
    f0 = fv_seen; s0 = se_seen;
    scan4(seg(1), seg(2), seg(3), seg(4), 8);
    chk("clean_fv_count", 16'(fv_seen - f0), 16'd1);
    chk("clean_se_count", 16'(se_seen - s0), 16'd0);
    chk("clean_digits", digits, 16'h4321);
    chk("clean_dp", {12'h0, dp}, 16'h0);
    chk("clean_err", {12'h0, digit_err}, 16'h0);

    // Glitch on digit 2 mid-phase
    f0 = fv_seen; s0 = se_seen;
    phase(4'b0001, seg(1), 8);
    phase(4'b0010, seg(2), 8);
    phase(4'b0100, seg(3), 2);
    phase(4'b0100, seg(3) ^ 8'h10, 2);
    phase(4'b0100, seg(3), 5);
    phase(4'b1000, seg(4), 8);
    phase(4'b0000, 8'hFF, 3);
    chk("glitch_fv_count", 16'(fv_seen - f0), 16'd1);
    chk("glitch_se_count", 16'(se_seen - s0), 16'd0);
    chk("glitch_digits", digits, 16'h4321);

    // Blank and invalid patterns, invalid one with its dp lit
    f0 = fv_seen;
    scan4(seg(0), 8'hFF, 8'b01010100, seg(4), 6);
    chk("inval_fv_count", 16'(fv_seen - f0), 16'd1);
    chk("inval_digits", digits, 16'h4EF0);
    chk("inval_err", {12'h0, digit_err}, 16'h0004);
    chk("inval_dp", {12'h0, dp}, 16'h0004);
    scan4(seg(0), 8'hFF, 8'b01010101, seg(4), 6);
    chk("inval2_digits", digits, 16'h4EF0);
    chk("inval2_err", {12'h0, digit_err}, 16'h0004);

    // Out of order 0,1,3 then a clean scan
    f0 = fv_seen; s0 = se_seen;
    phase(4'b0001, seg(0), 6);
    phase(4'b0010, seg(1), 6);
    phase(4'b1000, seg(3), 6);
    phase(4'b0000, 8'hFF, 3);
    chk("ooo_se_count", 16'(se_seen - s0), 16'd1);
    chk("ooo_fv_count", 16'(fv_seen - f0), 16'd0);
    chk("ooo_digits_held", digits, 16'h4EF0);
    scan4(seg(5), seg(6), seg(7), seg(8), 6);
    chk("ooo_recover_fv", 16'(fv_seen - f0), 16'd1);
    chk("ooo_recover_digits", digits, 16'h8765);

    // Multi-hot anode during COLLECT
    f0 = fv_seen; s0 = se_seen;
    phase(4'b0001, seg(9), 6);
    phase(4'b0010, seg(9), 6);
    phase(4'b0011, seg(9), 10);
    phase(4'b0000, 8'hFF, 3);
    chk("mhot_se_count", 16'(se_seen - s0), 16'd1);
    chk("mhot_fv_count", 16'(fv_seen - f0), 16'd0);
    chk("mhot_digits_held", digits, 16'h8765);

    // Reset after digit 2 has been captured
    phase(4'b0001, seg(1), 6);
    phase(4'b0010, seg(1), 6);
    phase(4'b0100, seg(1), 6);
    phase(4'b1000, seg(1), 2);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    m_reset();
    anode = 4'h0;
    cathode = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = fv_seen;
    scan4(seg(2), seg(0), seg(2), seg(6), 6);
    chk("post_reset_fv", 16'(fv_seen - f0), 16'd1);
    chk("post_reset_digits", digits, 16'h6202);

    // Randomized phases against the model
    ridx = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      sel = $urandom_range(0, 9);
      if (sel < 8) rc = {tab[$urandom_range(0, 9)], 1'($urandom_range(0, 1))};
      else if (sel == 8) rc = 8'hFF;
      else rc = 8'($urandom);
      if (r < 70) begin
        ra = 4'b0001 << ridx;
        ridx = (ridx + 1) % 4;
      end else if (r < 80) begin
        ra = 4'b0001 << $urandom_range(0, 3);
      end else if (r < 87) begin
        ra = 4'h3;
        while ($countones(ra) < 2) ra = 4'($urandom);
        while ($countones(ra) < 2 || ra == 4'h0) ra = 4'($urandom);
      end else begin
        ra = 4'h0;
      end
      if (ra == 4'h0) phase(ra, rc, $urandom_range(1, 3));
      else phase(ra, rc, $urandom_range(1, 9));
    end
    phase(4'b0000, 8'hFF, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
